ula_subarray_reconfig: RTL and testbench

ULA_SUBARRAY_RECONFIG -- requirements
Module: ula_subarray_reconfig

---
 rtl/ula_pkg.sv | 24 ++
 rtl/ula_subarray_reconfig_if.sv | 12 +
 rtl/ula_snap_buf.sv | 29 ++
 rtl/ula_subarray_reconfig.sv | 152 +++++++++++++++
 tb/tb_ula_subarray_reconfig.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared types and helpers for the ULA subarray reconfiguration block.
package ula_pkg;

    typedef enum logic [1:0] {FILL, DISCARD, DRAIN} state_t;

    localparam int ERR_W  = 8;
    localparam int HW_MAX = 32;

    // Negate a w-bit two's complement field (sign-extended into HW_MAX bits);
    // the most-negative value saturates to the most-positive one.
    function automatic logic [HW_MAX-1:0] sat_neg(input logic signed [HW_MAX-1:0] q,
                                                  input int unsigned w);
        localparam logic signed [HW_MAX:0] ONE = 1;
        logic signed [HW_MAX:0] lim;
        logic signed [HW_MAX:0] q_ext;
        logic signed [HW_MAX:0] r;
        lim   = ONE <<< (w - 1);
        q_ext = (HW_MAX+1)'(q);
        if (q_ext == -lim) r = lim - ONE;
        else               r = -q_ext;
        return r[HW_MAX-1:0];
    endfunction

endpackage

// File: rtl/ula_subarray_reconfig_if.sv
// AXI-stream style bundle used to wire the subarray block's streaming sides.
interface ula_stream_if #(
    parameter int DW = 32
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/ula_snap_buf.sv
// Snapshot buffer: N_ELEM x DW, one synchronous write port, one registered read port.
module ula_snap_buf #(
    parameter int N_ELEM = 8,
    parameter int DW     = 32,
    localparam int AW    = $clog2(N_ELEM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [N_ELEM];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Read register doubles as the output data register; it only advances on rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ula_subarray_reconfig.sv
// Buffers one array snapshot and streams a configurable subarray of it.
// ULA_FB_REVERSE_EN enables the backward (reversed, conjugated) subarray option.
module ula_subarray_reconfig
    import ula_pkg::*;
#(
    parameter int N_ELEM = 8,
    parameter int DW     = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [DW-1:0]             in_stream_TDATA,
    input  logic                      in_stream_TVALID,
    input  logic                      in_stream_TLAST,
    output logic                      in_stream_TREADY,
    output logic [DW-1:0]             out_stream_TDATA,
    output logic                      out_stream_TVALID,
    output logic                      out_stream_TLAST,
    input  logic                      out_stream_TREADY,
    input  logic [$clog2(N_ELEM)-1:0] cfg_start,
    input  logic [$clog2(N_ELEM):0]   cfg_len,
    input  logic                      cfg_rev,
    output logic [ERR_W-1:0]          err_cnt,
    output logic                      cfg_err
);

    localparam int AW = $clog2(N_ELEM);
    localparam logic [AW-1:0] LAST  = AW'(N_ELEM - 1);
    localparam logic [AW:0]   ONE_L = 1;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_idx, start_q, rd_addr;
    logic [AW:0]   len_q, iss_cnt, fwd_addr;
    logic [AW+1:0] cfg_end;
    logic [DW-1:0] rd_data;
    logic          rdy_en, out_vld, out_last;
    logic          accept, last_slot, cfg_ok, out_hs, rd_en;
    logic          wr_en, latch, err_inc, cfg_bad;

    assign accept    = in_stream_TVALID & in_stream_TREADY;
    assign last_slot = (wr_idx == LAST);
    assign cfg_end   = {2'b00, cfg_start} + {1'b0, cfg_len};
    assign cfg_ok    = (cfg_len != '0) && (cfg_end <= (AW+2)'(N_ELEM));
    assign out_hs    = out_vld & out_stream_TREADY;
    assign rd_en     = (state == DRAIN) && (iss_cnt != len_q) && (!out_vld || out_stream_TREADY);
    assign fwd_addr  = {1'b0, start_q} + iss_cnt;

`ifdef ULA_FB_REVERSE_EN
    localparam int HW = DW / 2;
    logic                   rev_q;
    logic [AW:0]            rev_addr;
    logic signed [HW-1:0]   q_s;
    logic [HW_MAX-1:0]      q_neg;
    assign rev_addr = {1'b0, start_q} + len_q - ONE_L - iss_cnt;
    assign rd_addr  = rev_q ? rev_addr[AW-1:0] : fwd_addr[AW-1:0];
    assign q_s      = rd_data[HW-1:0];
    assign q_neg    = sat_neg(HW_MAX'(q_s), HW);
    assign out_stream_TDATA = rev_q ? {rd_data[DW-1:HW], q_neg[HW-1:0]} : rd_data;
`else
    logic unused_rev;
    assign unused_rev       = cfg_rev;
    assign rd_addr          = fwd_addr[AW-1:0];
    assign out_stream_TDATA = rd_data;
`endif

    assign out_stream_TVALID = out_vld;
    assign out_stream_TLAST  = out_last;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        in_stream_TREADY = rdy_en && (state != DRAIN);
        wr_en            = 1'b0;
        latch            = 1'b0;
        err_inc          = 1'b0;
        cfg_bad          = 1'b0;
        case (state)
            FILL: if (accept) begin
                wr_en = 1'b1;
                if (last_slot && in_stream_TLAST) begin
                    latch = 1'b1;
                    if (cfg_ok) state_nxt = DRAIN;
                    else        cfg_bad   = 1'b1;
                end else if (last_slot) begin
                    state_nxt = DISCARD;
                end else if (in_stream_TLAST) begin
                    err_inc = 1'b1;
                end
            end
            DISCARD: if (accept && in_stream_TLAST) begin
                err_inc   = 1'b1;
                state_nxt = FILL;
            end
            DRAIN: if (out_hs && out_last) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rdy_en   <= 1'b0;
            wr_idx   <= '0;
            start_q  <= '0;
            len_q    <= '0;
            iss_cnt  <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            err_cnt  <= '0;
            cfg_err  <= 1'b0;
`ifdef ULA_FB_REVERSE_EN
            rev_q    <= 1'b0;
`endif
        end else begin
            rdy_en  <= 1'b1;
            cfg_err <= cfg_bad;
            if (wr_en) wr_idx <= (in_stream_TLAST || last_slot) ? '0 : wr_idx + AW'(1);
            if (latch) begin
                start_q <= cfg_start;
                len_q   <= cfg_len;
`ifdef ULA_FB_REVERSE_EN
                rev_q   <= cfg_rev;
`endif
            end
            if (err_inc && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (latch)      iss_cnt <= '0;
            else if (rd_en) iss_cnt <= iss_cnt + ONE_L;
            // A new read only lands when the output slot is empty or being consumed.
            if (rd_en) begin
                out_vld  <= 1'b1;
                out_last <= ((iss_cnt + ONE_L) == len_q);
            end else if (out_stream_TREADY) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

    ula_snap_buf #(.N_ELEM(N_ELEM), .DW(DW)) u_buf (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .we      (wr_en),
        .wr_addr (wr_idx),
        .wr_data (in_stream_TDATA),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_ula_subarray_reconfig.sv
// Randomized bench for ula_subarray_reconfig against a queue-based snapshot model.
module tb_ula_subarray_reconfig;

    localparam int N  = 8;
    localparam int DW = 32;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b1;
    logic [2:0] cfg_start = '0;
    logic [3:0] cfg_len   = '0;
    logic       cfg_rev   = 1'b0;
    logic [7:0] err_cnt;
    logic       cfg_err;

    ula_stream_if #(.DW(DW)) s_in ();
    ula_stream_if #(.DW(DW)) s_out ();

    always #5 ap_clk = ~ap_clk;

    ula_subarray_reconfig #(.N_ELEM(N), .DW(DW)) dut (
        .ap_clk            (ap_clk),
        .ap_rst            (ap_rst),
        .in_stream_TDATA   (s_in.tdata),
        .in_stream_TVALID  (s_in.tvalid),
        .in_stream_TLAST   (s_in.tlast),
        .in_stream_TREADY  (s_in.tready),
        .out_stream_TDATA  (s_out.tdata),
        .out_stream_TVALID (s_out.tvalid),
        .out_stream_TLAST  (s_out.tlast),
        .out_stream_TREADY (s_out.tready),
        .cfg_start         (cfg_start),
        .cfg_len           (cfg_len),
        .cfg_rev           (cfg_rev),
        .err_cnt           (err_cnt),
        .cfg_err           (cfg_err)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q_exp[$];
    int          exp_err = 0;
    int          exp_cfgerr = 0;
    int          seen_cfgerr = 0;
    int          hs_cnt = 0;
    bit          bp_en = 1'b0;
    bit          gaps = 1'b0;
    logic [31:0] snap [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] conj(input logic [31:0] w);
        logic [15:0] q;
        q = w[15:0];
        return {w[31:16], (q == 16'h8000) ? 16'h7fff : 16'(16'h0 - q)};
    endfunction

    // Reference: a complete N-word snapshot with valid config yields the subarray.
    task automatic model_snap(input int nw, input int st, input int ln, input bit rv);
        bit   rv_eff;
        int   idx;
        exp_t e;
`ifdef ULA_FB_REVERSE_EN
        rv_eff = rv;
`else
        rv_eff = 1'b0;
`endif
        if (nw != N) begin
            if (exp_err < 255) exp_err++;
        end else if (ln < 1 || st + ln > N) begin
            exp_cfgerr++;
        end else begin
            for (int k = 0; k < ln; k++) begin
                idx = rv_eff ? (st + ln - 1 - k) : (st + k);
                e.d = rv_eff ? conj(snap[idx]) : snap[idx];
                e.l = (k == ln - 1);
                q_exp.push_back(e);
            end
        end
    endtask

    task automatic send_snap(input int nw, input int st, input int ln, input bit rv);
        int t;
        cfg_start = 3'(st);
        cfg_len   = 4'(ln);
        cfg_rev   = rv;
        for (int i = 0; i < nw; i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                s_in.tvalid = 1'b0;
                @(posedge ap_clk); #1;
            end
            s_in.tvalid = 1'b1;
            s_in.tdata  = snap[i];
            s_in.tlast  = (i == nw - 1);
            t = 0;
            @(negedge ap_clk);
            while (!s_in.tready && t < 300) begin
                @(negedge ap_clk);
                t++;
            end
            if (t >= 300) chk("in_ready_timeout", 32'(t), 0);
            @(posedge ap_clk); #1;
        end
        s_in.tvalid = 1'b0;
        s_in.tlast  = 1'b0;
        model_snap(nw, st, ln, rv);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q_exp.size() != 0 && t < 3000) begin
            @(negedge ap_clk);
            t++;
        end
        chk("drain_timeout", 32'(q_exp.size()), 0);
        repeat (3) @(posedge ap_clk);
        #1;
    endtask

    // Output monitor: scoreboard compare on handshakes, hold checks during stalls.
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall = 1'b0;
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cfg_err) seen_cfgerr++;
            if (prev_stall) begin
                chk("stall_valid", 32'(s_out.tvalid), 1);
                chk("stall_data", s_out.tdata, prev_data);
                chk("stall_last", 32'(s_out.tlast), 32'(prev_last));
            end
            if (s_out.tvalid && s_out.tready) begin
                hs_cnt++;
                if (q_exp.size() == 0) begin
                    chk("out_unexpected", s_out.tdata, 0);
                    chk("out_unexpected_vld", 32'(s_out.tvalid), 0);
                end else begin
                    e = q_exp.pop_front();
                    chk("out_data", s_out.tdata, e.d);
                    chk("out_last", 32'(s_out.tlast), 32'(e.l));
                end
            end
            prev_stall = s_out.tvalid && !s_out.tready;
            prev_data  = s_out.tdata;
            prev_last  = s_out.tlast;
        end
    end

    initial begin
        s_out.tready = 1'b1;
        forever begin
            @(posedge ap_clk); #1;
            s_out.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, h0, nw, st, ln, r;
        bit rv;
        s_in.tvalid = 1'b0;
        s_in.tlast  = 1'b0;
        s_in.tdata  = '0;

        // Reset state
        repeat (3) @(negedge ap_clk);
        chk("rst_in_ready", 32'(s_in.tready), 0);
        chk("rst_out_valid", 32'(s_out.tvalid), 0);
        chk("rst_out_data", s_out.tdata, 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("ready_after_rst", 32'(s_in.tready), 1);
        @(posedge ap_clk); #1;

        // Forward subarray, I = k+1
        for (int k = 0; k < N; k++) snap[k] = 32'(k + 1) << 16;
        send_snap(N, 2, 4, 1'b0);
        chk("fwd_first_exp", q_exp[0].d, 32'h0003_0000);
        cnt = 0;
        @(negedge ap_clk);
        while (!s_in.tready && cnt < 100) begin
            cnt++;
            @(negedge ap_clk);
        end
        chk("ready_low_min5", 32'(cnt >= 5), 1);
        wait_drain();

        // Reverse/conjugate request, including the most-negative Q
        for (int k = 0; k < N; k++) snap[k] = (32'(k + 1) << 16) | 32'(k + 1);
        send_snap(N, 2, 4, 1'b1);
        wait_drain();
        snap[4] = 32'h0005_8000;
        send_snap(N, 2, 4, 1'b1);
        wait_drain();

        // Short snapshot, then a normal one
        send_snap(5, 0, 8, 1'b0);
        repeat (2) @(posedge ap_clk); #1;
        chk("short_err_cnt", 32'(err_cnt), 1);
        send_snap(N, 0, 8, 1'b0);
        wait_drain();

        // Long snapshot
        for (int k = 0; k < 10; k++) snap[k] = 32'(k + 1) << 16;
        send_snap(10, 0, 4, 1'b0);
        repeat (2) @(posedge ap_clk); #1;
        chk("long_err_cnt", 32'(err_cnt), 2);

        // Invalid configs
        send_snap(N, 6, 4, 1'b0);
        repeat (2) @(posedge ap_clk); #1;
        chk("cfg_err_pulse", 32'(seen_cfgerr), 1);
        send_snap(N, 0, 0, 1'b0);
        repeat (2) @(posedge ap_clk); #1;
        chk("cfg_err_len0", 32'(seen_cfgerr), 2);
        send_snap(N, 7, 1, 1'b1);
        wait_drain();

        // Randomized snapshots under backpressure
        bp_en = 1'b1;
        gaps  = 1'b1;
        for (int s = 0; s < 100; s++) begin
            r  = int'($urandom % 10);
            nw = (r == 0) ? int'($urandom_range(1, N - 1)) :
                 (r == 1) ? int'($urandom_range(N + 1, 12)) : N;
            st = int'($urandom % N);
            ln = (r == 2) ? (N - st + 1) : int'($urandom_range(1, N - st));
            rv = 1'($urandom % 2);
            for (int k = 0; k < 16; k++) begin
                snap[k] = $urandom;
                if ($urandom % 8 == 0) snap[k][15:0] = 16'h8000;
            end
            send_snap(nw, st, ln, rv);
        end
        wait_drain();
        chk("rand_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("rand_cfg_err", 32'(seen_cfgerr), 32'(exp_cfgerr));

        // Reset in the middle of a drain
        bp_en = 1'b0;
        gaps  = 1'b0;
        for (int k = 0; k < N; k++) snap[k] = 32'hA000_0000 | 32'(k);
        h0 = hs_cnt;
        send_snap(N, 0, 4, 1'b0);
        cnt = 0;
        while (hs_cnt < h0 + 2 && cnt < 50) begin
            @(negedge ap_clk); #1;
            cnt++;
        end
        chk("mid_drain_reached", 32'(hs_cnt - h0), 2);
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(s_out.tvalid), 0);
        chk("mid_rst_data", s_out.tdata, 0);
        chk("mid_rst_ready", 32'(s_in.tready), 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        q_exp.delete();
        exp_err     = 0;
        exp_cfgerr  = 0;
        seen_cfgerr = 0;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        for (int k = 0; k < N; k++) snap[k] = 32'hB000_0000 | 32'(k * 3);
        h0 = hs_cnt;
        send_snap(N, 1, 4, 1'b0);
        wait_drain();
        chk("post_rst_words", 32'(hs_cnt - h0), 4);
        chk("post_rst_err_cnt", 32'(err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
